// File: rtl/mips_pkg.sv
// Shared definitions for the parametrised MIPS-style register file:
// default geometry, clear-engine state encoding and the hardwired-zero address.
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;

   // Address of the register that reads as zero when the zero register is enabled
   localparam int REG_ZERO = 0;

   // CLEAR walks the array writing zeros; RUN is normal operation
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clear_state_e;

endpackage

// File: rtl/mp_register_file_read_port.sv
// One combinational read port: array data, hardwired zero register and
// same-cycle write-to-read bypass (write port 1 has priority over port 0).
module rf_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              write_enable0,
   input  logic [ADDR_W-1:0] write_reg0,
   input  logic [DATA_W-1:0] write_data0,
   input  logic              write_enable1,
   input  logic [ADDR_W-1:0] write_reg1,
   input  logic [DATA_W-1:0] write_data1,
   output logic [DATA_W-1:0] data
);

   logic is_zero;
   logic hit0;
   logic hit1;

   // Select the operand: zero while clearing or for register 0, else the newest value
   always_comb begin
      is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
      hit0    = (BYPASS != 0) && write_enable0 && (write_reg0 == addr);
      hit1    = (BYPASS != 0) && write_enable1 && (write_reg1 == addr);
      data    = mem_data;
      if (!ready || is_zero) begin
         data = '0;
      end else if (hit1) begin
         data = write_data1;
      end else if (hit0) begin
         data = write_data0;
      end
   end

endmodule

// File: rtl/mp_register_file.sv
// Parametrised multi-read, dual-write register file. Storage is cleared one
// entry per cycle after reset so the array carries no reset and can map to
// distributed RAM; ready holds off the pipeline until the clear is done.
module mp_register_file
   import mips_pkg::*;
#(
   parameter int  DATA_W   = DATA_W_DEF,
   parameter int  DEPTH    = DEPTH_DEF,
   parameter int  NUM_RD   = 2,
   parameter int  ZERO_REG = 1,
   parameter int  BYPASS   = 1,
   localparam int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] read_reg,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   input  logic [ADDR_W-1:0]        write_reg0,
   input  logic [ADDR_W-1:0]        write_reg1,
   input  logic [DATA_W-1:0]        write_data0,
   input  logic [DATA_W-1:0]        write_data1,
   input  logic                     write_enable0,
   input  logic                     write_enable1,
   output logic                     ready,
   output logic                     conflict
);

   clear_state_e      state;
   clear_state_e      state_next;
   logic [ADDR_W-1:0] clear_idx;
   logic [ADDR_W-1:0] clear_idx_next;
   logic              wr_ok0;
   logic              wr_ok1;
   logic              conflict_next;

   logic [DATA_W-1:0] mem [DEPTH];

   // Clear engine: step through every entry, then settle in RUN until the next reset
   always_comb begin
      state_next     = state;
      clear_idx_next = clear_idx;
      case (state)
         CLEAR: begin
            clear_idx_next = clear_idx + 1'b1;
            if (clear_idx == ADDR_W'(DEPTH - 1)) begin
               state_next = RUN;
            end
         end
         RUN:     state_next = RUN;
         default: state_next = CLEAR;
      endcase
   end

   // Qualify write strobes: only in RUN, and never into the hardwired zero register
   always_comb begin
      wr_ok0 = (state == RUN) && write_enable0 &&
               !((ZERO_REG != 0) && (write_reg0 == ADDR_W'(REG_ZERO)));
      wr_ok1 = (state == RUN) && write_enable1 &&
               !((ZERO_REG != 0) && (write_reg1 == ADDR_W'(REG_ZERO)));
      conflict_next = (state == RUN) && write_enable0 && write_enable1 &&
                      (write_reg0 == write_reg1) &&
                      !((ZERO_REG != 0) && (write_reg0 == ADDR_W'(REG_ZERO)));
   end

   // Control state with synchronous active-low reset; reset restarts the clear from 0
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= CLEAR;
         clear_idx <= '0;
         conflict  <= 1'b0;
      end else begin
         state     <= state_next;
         clear_idx <= clear_idx_next;
         conflict  <= conflict_next;
      end
   end

   // Array update: zero one entry per cycle while clearing, else the two write ports (port 1 wins)
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state == CLEAR) begin
            mem[clear_idx] <= '0;
         end else begin
            if (wr_ok0) begin
               mem[write_reg0] <= write_data0;
            end
            if (wr_ok1) begin
               mem[write_reg1] <= write_data1;
            end
         end
      end
   end

   assign ready = (state == RUN);

   // One read mux per port, each looking up the array at its own address
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = read_reg[k*ADDR_W +: ADDR_W];

      rf_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_REG(ZERO_REG),
         .BYPASS  (BYPASS)
      ) u_port (
         .ready        (ready),
         .addr         (addr),
         .mem_data     (mem[addr]),
         .write_enable0(write_enable0),
         .write_reg0   (write_reg0),
         .write_data0  (write_data0),
         .write_enable1(write_enable1),
         .write_reg1   (write_reg1),
         .write_data1  (write_data1),
         .data         (read_data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_mp_register_file.sv
// Scoreboard bench for mp_register_file at default parameters: stimulus pushes
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_mp_register_file;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   localparam int K_RD   = 0;
   localparam int K_RDY  = 1;
   localparam int K_CONF = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR*AW-1:0] read_reg;
   logic [NR*DW-1:0] read_data;
   logic [AW-1:0]    write_reg0;
   logic [AW-1:0]    write_reg1;
   logic [DW-1:0]    write_data0;
   logic [DW-1:0]    write_data1;
   logic             write_enable0;
   logic             write_enable1;
   logic             ready;
   logic             conflict;

   typedef struct {
      int          kind;
      int          port;
      logic [31:0] value;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   mp_register_file dut (
      .clk          (clk),
      .reset        (reset),
      .read_reg     (read_reg),
      .read_data    (read_data),
      .write_reg0   (write_reg0),
      .write_reg1   (write_reg1),
      .write_data0  (write_data0),
      .write_data1  (write_data1),
      .write_enable0(write_enable0),
      .write_enable1(write_enable1),
      .ready        (ready),
      .conflict     (conflict)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Monitor: outputs are stable at the falling edge, so drain the scoreboard there
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_RD:    act = read_data[e.port*DW +: DW];
            K_RDY:   act = {31'b0, ready};
            default: act = {31'b0, conflict};
         endcase
         total++;
         if (act !== e.value) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", e.name, act, e.value);
         end
      end
   end

   // Hard stop if the run somehow stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive read addresses and both write ports for the current cycle
   task automatic apply_stimulus(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                 input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      read_reg      = {r1, r0};
      write_enable0 = e0;
      write_reg0    = a0;
      write_data0   = d0;
      write_enable1 = e1;
      write_reg1    = a1;
      write_data1   = d1;
   endtask

   // Queue an expectation for the monitor to check at this cycle's falling edge
   task automatic check_output(input int kind, input int port, input logic [31:0] value,
                               input string name);
      exp_t e;
      e.kind  = kind;
      e.port  = port;
      e.value = value;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Expected contents after the walking-one sweep
   function automatic logic [31:0] walk_val(input int addr);
      if (addr == 0) return 32'h0;
      return 32'h1 << (addr - 1);
   endfunction

   // Read every register pair by pair and expect zero
   task automatic read_all_zero(input string tag);
      for (int j = 0; j < 16; j++) begin
         apply_stimulus(AW'(2*j), AW'(2*j+1), 1'b0, '0, '0, 1'b0, '0, '0);
         check_output(K_RD, 0, 32'h0, $sformatf("%s_r%0d", tag, 2*j));
         check_output(K_RD, 1, 32'h0, $sformatf("%s_r%0d", tag, 2*j+1));
         step();
      end
   endtask

   // Count DEPTH edges after reset release: ready low until the 32nd, reads zero meanwhile
   task automatic watch_clear(input string tag);
      for (int e = 1; e <= 32; e++) begin
         step();
         if (e == 5) begin
            apply_stimulus(5'd3, 5'd5, 1'b0, '0, '0, 1'b0, '0, '0);
         end
         check_output(K_RDY, 0, (e == 32) ? 32'h1 : 32'h0, $sformatf("%s_ready_e%0d", tag, e));
         if (e < 32) begin
            check_output(K_RD, 0, 32'h0, $sformatf("%s_rd0_e%0d", tag, e));
            check_output(K_RD, 1, 32'h0, $sformatf("%s_rd1_e%0d", tag, e));
         end
      end
   endtask

   initial begin
      // Reset held for two edges
      reset = 1'b0;
      apply_stimulus(5'd0, 5'd1, 1'b0, '0, '0, 1'b0, '0, '0);
      repeat (2) begin
         step();
         check_output(K_RDY, 0, 32'h0, "reset_ready");
         check_output(K_CONF, 0, 32'h0, "reset_conflict");
         check_output(K_RD, 0, 32'h0, "reset_rd0");
         check_output(K_RD, 1, 32'h0, "reset_rd1");
      end

      // Release and clear, with a write strobe to reg 3 during the first edges
      reset = 1'b1;
      apply_stimulus(5'd3, 5'd5, 1'b1, 5'd3, 32'h5, 1'b0, '0, '0);
      watch_clear("clr");
      read_all_zero("post_clear");

      // Write reg 5 via port 0: bypass in the write cycle, stored afterwards
      apply_stimulus(5'd5, 5'd5, 1'b1, 5'd5, 32'hAAAAAAAA, 1'b0, '0, '0);
      check_output(K_RD, 0, 32'hAAAAAAAA, "bypass_r5_p0");
      check_output(K_RD, 1, 32'hAAAAAAAA, "bypass_r5_p1");
      step();
      apply_stimulus(5'd0, 5'd5, 1'b0, '0, '0, 1'b0, '0, '0);
      check_output(K_RD, 1, 32'hAAAAAAAA, "stored_r5_p1");
      check_output(K_RD, 0, 32'h0, "zero_r0_p0");
      step();

      // Walking-one sweep, alternating write ports, bypass checked each cycle
      for (int i = 1; i < 32; i++) begin
         if (i % 2 == 1) begin
            apply_stimulus(AW'(i), 5'd0, 1'b1, AW'(i), walk_val(i), 1'b0, '0, '0);
         end else begin
            apply_stimulus(AW'(i), 5'd0, 1'b0, '0, '0, 1'b1, AW'(i), walk_val(i));
         end
         check_output(K_RD, 0, walk_val(i), $sformatf("walk_bypass_r%0d", i));
         step();
      end
      apply_stimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
      check_output(K_RD, 0, 32'h0, "r0_write_bypass");
      step();
      for (int j = 0; j < 16; j++) begin
         apply_stimulus(AW'(2*j), AW'(2*j+1), 1'b0, '0, '0, 1'b0, '0, '0);
         check_output(K_RD, 0, walk_val(2*j), $sformatf("walk_r%0d", 2*j));
         check_output(K_RD, 1, walk_val(2*j+1), $sformatf("walk_r%0d", 2*j+1));
         step();
      end

      // Both ports to reg 7: port 1 wins, conflict pulses once
      apply_stimulus(5'd7, 5'd7, 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
      check_output(K_RD, 0, 32'h22222222, "conf_bypass_r7");
      check_output(K_CONF, 0, 32'h0, "conf_before");
      step();
      apply_stimulus(5'd7, 5'd6, 1'b0, '0, '0, 1'b0, '0, '0);
      check_output(K_CONF, 0, 32'h1, "conf_pulse");
      check_output(K_RD, 0, 32'h22222222, "conf_r7");
      check_output(K_RD, 1, walk_val(6), "conf_r6");
      step();

      // Distinct addresses: both stored, no conflict
      apply_stimulus(5'd8, 5'd9, 1'b1, 5'd8, 32'h33333333, 1'b1, 5'd9, 32'h44444444);
      check_output(K_CONF, 0, 32'h0, "conf_one_cycle");
      check_output(K_RD, 0, 32'h33333333, "dist_bypass_r8");
      check_output(K_RD, 1, 32'h44444444, "dist_bypass_r9");
      step();
      apply_stimulus(5'd8, 5'd9, 1'b0, '0, '0, 1'b0, '0, '0);
      check_output(K_CONF, 0, 32'h0, "dist_conf");
      check_output(K_RD, 0, 32'h33333333, "dist_r8");
      check_output(K_RD, 1, 32'h44444444, "dist_r9");
      step();

      // Both ports to reg 0: dropped, and no conflict for the zero register
      apply_stimulus(5'd0, 5'd7, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hCAFEF00D);
      check_output(K_RD, 0, 32'h0, "r0_dual_bypass");
      check_output(K_RD, 1, 32'h22222222, "r7_kept");
      step();
      apply_stimulus(5'd0, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0);
      check_output(K_CONF, 0, 32'h0, "r0_no_conflict");
      check_output(K_RD, 0, 32'h0, "r0_dual_read");
      step();

      // Reset from RUN, abort the clear at index 10, then a full restart
      reset = 1'b0;
      step();
      check_output(K_RDY, 0, 32'h0, "rerun_ready");
      check_output(K_RD, 1, 32'h0, "rerun_rd1");
      reset = 1'b1;
      repeat (10) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_output(K_RDY, 0, 32'h0, "midclear_ready");
      watch_clear("reclr");
      read_all_zero("post_reclear");

      // Every queued expectation must have been consumed
      step();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
